// File: rtl/uart_rx_framer.sv
// UART 8N1 receiver: synchronizes the line, frames start/data/stop, presents bytes with valid/ready.
// Latency: line falling edge to data_valid is 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks.
// Backpressure: one-byte output holding register; a byte completing while it is still occupied is dropped and flagged on overrun.
//
// Ports:
//   clk_pin      system clock, rising edge
//   rst          asynchronous active-high reset
//   uart_rx_pin  raw serial line, idle high
//   data_out     received byte, LSB = first data bit on the wire
//   data_valid   data_out holds an unconsumed byte
//   data_ready   consumer takes data_out in a cycle where data_valid=1
//   frame_err    one-cycle pulse: stop bit sampled low
//   overrun      one-cycle pulse: completed byte dropped, output occupied
//   busy         receiver is inside a frame (FSM not IDLE)
module uart_rx_framer #(
  parameter int CLKS_PER_BIT = 234
) (
  input  logic       clk_pin,
  input  logic       rst,
  input  logic       uart_rx_pin,
  output logic [7:0] data_out,
  output logic       data_valid,
  input  logic       data_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            rx_meta;
  logic            rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;

  logic            half_hit;
  logic            bit_hit;
  logic            cnt_clr;
  logic            shift_en;
  logic            byte_done;
  logic            stop_bad;

  // Synchronizer resets to the idle level so a reset never looks like a start edge.
  always_ff @(posedge clk_pin or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rx_pin;
      rx_s    <= rx_meta;
    end
  end

  assign half_hit = (cnt == HALF_LAST);
  assign bit_hit  = (cnt == BIT_LAST);

  // State register
  always_ff @(posedge clk_pin or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!rx_s) state_nxt = START;
      START:     if (half_hit) state_nxt = rx_s ? IDLE : DATA;
      DATA:      if (bit_hit && (idx == 3'd7)) state_nxt = STOP;
      STOP:      if (bit_hit) state_nxt = rx_s ? IDLE : WAIT_IDLE;
      WAIT_IDLE: if (rx_s) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy      = (state != IDLE);
    shift_en  = (state == DATA) && bit_hit;
    byte_done = (state == STOP) && bit_hit && rx_s;
    stop_bad  = (state == STOP) && bit_hit && !rx_s;
    // The counter only runs inside a bit period; it is held at zero while waiting.
    cnt_clr   = (state == IDLE) || (state == WAIT_IDLE) ||
                ((state == START) && half_hit) ||
                (((state == DATA) || (state == STOP)) && bit_hit);
  end

  // Bit-period counter and data-bit index
  always_ff @(posedge clk_pin or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      idx <= 3'd0;
    end else begin
      if (cnt_clr) cnt <= '0;
      else         cnt <= cnt + CW'(1);
      if (state == START)  idx <= 3'd0;
      else if (shift_en)   idx <= idx + 3'd1;
    end
  end

  always_ff @(posedge clk_pin or posedge rst) begin
    if (rst)           shreg      <= 8'h00;
    else if (shift_en) shreg[idx] <= rx_s;
  end

  // Output holding register. A completing byte may replace the held one only
  // when the consumer takes the old one in the same cycle; otherwise it is dropped.
  always_ff @(posedge clk_pin or posedge rst) begin
    if (rst) begin
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= byte_done && data_valid && !data_ready;
      if (byte_done && (!data_valid || data_ready)) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_framer.sv
// Directed bench for uart_rx_framer at 8 clocks per bit.
// Line driven on the falling clock edge; outputs sampled on the falling edge.
// Pulses and data_valid rising edges are tallied by a free-running monitor.
module tb_uart_rx_framer;

  localparam int CPB = 8;

  logic       clk_pin;
  logic       rst;
  logic       uart_rx_pin;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  uart_rx_framer #(.CLKS_PER_BIT(CPB)) dut (
    .clk_pin     (clk_pin),
    .rst         (rst),
    .uart_rx_pin (uart_rx_pin),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .frame_err   (frame_err),
    .overrun     (overrun),
    .busy        (busy)
  );

  initial clk_pin = 1'b0;
  always #5 clk_pin = ~clk_pin;

  int cyc = 0;
  always @(posedge clk_pin) cyc++;

  // Monitor
  int         n_fe = 0;
  int         n_ov = 0;
  int         n_busy = 0;
  int         n_rise = 0;
  int         ov_cyc = 0;
  logic       dv_q = 1'b0;
  logic [7:0] got_q[$];
  int         rise_cyc_q[$];

  always @(negedge clk_pin) begin
    if (frame_err) n_fe++;
    if (overrun) begin
      n_ov++;
      ov_cyc = cyc;
    end
    if (busy) n_busy++;
    if (data_valid && !dv_q) begin
      n_rise++;
      got_q.push_back(data_out);
      rise_cyc_q.push_back(cyc);
    end
    dv_q = data_valid;
  end

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_pin);
  endtask

  int t_fall = 0;

  task automatic send_frame(input logic [7:0] b, input logic stop_val, input int stop_len);
    t_fall = cyc;
    uart_rx_pin = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx_pin = b[i];
      tick(CPB);
    end
    uart_rx_pin = stop_val;
    tick(stop_len);
  endtask

  int r0, fe0, ov0, b0, q0, t_first, lat;

  initial begin
    rst = 1'b1;
    uart_rx_pin = 1'b1;
    data_ready = 1'b0;
    tick(3);
    check("rst_data_out",   32'(data_out),   32'h00);
    check("rst_data_valid", 32'(data_valid), 32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_frame_err",  32'(frame_err),  32'h0);
    check("rst_overrun",    32'(overrun),    32'h0);
    rst = 1'b0;
    tick(4);

    // Two frames back to back, first with a shortened stop bit; consumer always ready
    data_ready = 1'b1;
    r0 = n_rise; fe0 = n_fe; ov0 = n_ov; q0 = got_q.size();
    send_frame(8'h55, 1'b1, 6);
    t_first = t_fall;
    send_frame(8'hA3, 1'b1, CPB);
    tick(16);
    check("b2b_rises", 32'(n_rise - r0), 32'd2);
    if (n_rise - r0 >= 2) begin
      check("b2b_byte0", 32'(got_q[q0]),     32'h55);
      check("b2b_byte1", 32'(got_q[q0 + 1]), 32'hA3);
      lat = rise_cyc_q[q0] - t_first;
      check("latency_window", 32'((lat >= 78) && (lat <= 80)), 32'd1);
    end
    check("b2b_frame_err", 32'(n_fe - fe0), 32'd0);
    check("b2b_overrun",   32'(n_ov - ov0), 32'd0);
    check("b2b_consumed",  32'(data_valid), 32'h0);

    // Start-bit glitch of two clocks
    b0 = n_busy; r0 = n_rise; fe0 = n_fe;
    uart_rx_pin = 1'b0;
    tick(2);
    uart_rx_pin = 1'b1;
    tick(30);
    check("glitch_busy_seen", 32'(n_busy > b0),  32'd1);
    check("glitch_idle",      32'(busy),         32'h0);
    check("glitch_no_data",   32'(n_rise - r0),  32'd0);
    check("glitch_no_fe",     32'(n_fe - fe0),   32'd0);

    // Bad stop bit followed by a long break
    r0 = n_rise; fe0 = n_fe;
    send_frame(8'h3C, 1'b0, CPB);
    tick(40);
    check("break_busy", 32'(busy), 32'h1);
    uart_rx_pin = 1'b1;
    tick(6);
    check("break_idle",     32'(busy),        32'h0);
    check("break_fe_once",  32'(n_fe - fe0),  32'd1);
    check("break_no_data",  32'(n_rise - r0), 32'd0);
    check("break_valid",    32'(data_valid),  32'h0);
    tick(10);

    // Overrun: consumer stalled across two frames
    data_ready = 1'b0;
    send_frame(8'h11, 1'b1, CPB);
    tick(4);
    check("ovr_valid1", 32'(data_valid), 32'h1);
    check("ovr_data1",  32'(data_out),   32'h11);
    ov0 = n_ov; fe0 = n_fe;
    send_frame(8'h22, 1'b1, CPB);
    tick(4);
    check("ovr_pulse",      32'(n_ov - ov0), 32'd1);
    lat = ov_cyc - t_fall;
    check("ovr_at_stop",    32'((lat >= 78) && (lat <= 80)), 32'd1);
    check("ovr_data_kept",  32'(data_out),   32'h11);
    check("ovr_valid_kept", 32'(data_valid), 32'h1);
    check("ovr_no_fe",      32'(n_fe - fe0), 32'd0);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    check("ovr_drained", 32'(data_valid), 32'h0);
    tick(8);

    // Reset in the middle of data bit 4 of 0xFF
    r0 = n_rise; fe0 = n_fe; ov0 = n_ov;
    uart_rx_pin = 1'b0;
    tick(CPB);
    uart_rx_pin = 1'b1;
    tick(CPB * 4 + 3);
    rst = 1'b1;
    tick(2);
    check("midrst_busy",     32'(busy),     32'h0);
    check("midrst_data_out", 32'(data_out), 32'h00);
    rst = 1'b0;
    tick(CPB * 4 + 20);
    check("midrst_no_data", 32'(n_rise - r0), 32'd0);
    check("midrst_no_fe",   32'(n_fe - fe0),  32'd0);
    check("midrst_no_ov",   32'(n_ov - ov0),  32'd0);
    check("midrst_idle",    32'(busy),        32'h0);
    send_frame(8'h81, 1'b1, CPB);
    tick(4);
    check("midrst_valid", 32'(data_valid), 32'h1);
    check("midrst_byte",  32'(data_out),   32'h81);
    data_ready = 1'b1;
    tick(1);
    data_ready = 1'b0;
    tick(8);

    // Consumer takes the held byte exactly on the stop-sample cycle of the next one
    send_frame(8'h10, 1'b1, CPB);
    tick(4);
    check("swap_valid0", 32'(data_valid), 32'h1);
    check("swap_data0",  32'(data_out),   32'h10);
    ov0 = n_ov; r0 = n_rise;
    fork
      send_frame(8'h20, 1'b1, CPB);
      begin
        tick(78);
        data_ready = 1'b1;
        tick(1);
        data_ready = 1'b0;
      end
    join
    tick(4);
    check("swap_valid1",   32'(data_valid),  32'h1);
    check("swap_data1",    32'(data_out),    32'h20);
    check("swap_no_ov",    32'(n_ov - ov0),  32'd0);
    check("swap_no_rise",  32'(n_rise - r0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_framer.md
UART_RX_FRAMER -- requirements
Module: uart_rx_framer

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, clocks per UART bit (27 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk_pin  input  1  single system clock; all logic on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port uart_rx_pin  input  1  asynchronous serial line, 8N1, idle high.
REQ-005 SHALL have port data_out  output  8  last received byte, LSB = first data bit.
REQ-006 SHALL have port data_valid  output  1  data_out holds an unconsumed byte.
REQ-007 SHALL have port data_ready  input  1  consumer accepts data_out this cycle when data_valid=1.
REQ-008 SHALL have port frame_err  output  1  one-cycle pulse, stop bit sampled low.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse, completed byte dropped because the output was occupied.
REQ-010 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 SHALL pass uart_rx_pin through a 2-flop synchronizer; all FSM decisions use the synchronized value (rx_s).
REQ-012 SHALL implement FSM states IDLE, START, DATA, STOP, WAIT_IDLE, with a bit-period counter of width clog2(CLKS_PER_BIT) and a 3-bit data-bit index.
REQ-013 IDLE: rx_s=0 -> START, counter cleared; rx_s=1 -> stay.
REQ-014 START: when counter reaches CLKS_PER_BIT/2-1 (integer divide), sample rx_s; 0 -> DATA, counter cleared, index 0; 1 -> IDLE (glitch rejected, no output activity).
REQ-015 DATA: when counter reaches CLKS_PER_BIT-1, shift rx_s into the shift register at bit[index] (LSB first), clear counter; after index 7 -> STOP.
REQ-016 STOP: when counter reaches CLKS_PER_BIT-1, sample rx_s; 1 -> byte complete, go IDLE; 0 -> pulse frame_err, discard byte, go WAIT_IDLE.
REQ-017 WAIT_IDLE: stay until rx_s=1, then IDLE; a held-low line (break) SHALL produce exactly one frame_err.
REQ-018 On byte complete with data_valid=0: load data_out, assert data_valid on the next cycle.
REQ-019 On byte complete with data_valid=1 and data_ready=1 in the same cycle: load new byte, data_valid stays 1, no overrun.
REQ-020 On byte complete with data_valid=1 and data_ready=0: keep old data_out, pulse overrun, drop new byte.
REQ-021 data_valid SHALL clear the cycle after data_valid=1 and data_ready=1 unless REQ-019 applies; data_out SHALL be stable while data_valid=1.
REQ-022 data_ready while data_valid=0 SHALL have no effect.
REQ-023 Latency, uart_rx_pin falling edge at start to data_valid high: 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 clocks (±1 for edge alignment).
REQ-024 Receiver SHALL accept back-to-back frames (next start bit immediately after a half stop bit elapsed) without loss.
REQ-025 frame_err and overrun SHALL never be asserted in the same cycle as a new data_valid rising edge for the same frame.

Reset
REQ-026 rst=1 SHALL immediately force: FSM IDLE, counters 0, synchronizer flops 1, shift register 0x00, data_out 0x00, data_valid 0, frame_err 0, overrun 0, busy 0.
REQ-027 Reset mid-frame SHALL abandon the frame with no data_valid, frame_err or overrun; after release, the receiver SHALL wait for rx_s high-to-low before starting a frame.

Verification (CLKS_PER_BIT=8)
REQ-028 Send 0x55 then 0xA3, data_ready=1 -> data_valid pulses twice, data_out 0x55 then 0xA3, no frame_err/overrun.
REQ-029 Drive line low for 2 clocks then high -> busy briefly high, returns IDLE, no data_valid, no frame_err.
REQ-030 Send 0x3C with stop bit 0, line then held low 40 clocks -> exactly one frame_err pulse, data_valid stays 0, busy until line high.
REQ-031 data_ready=0, send 0x11 then 0x22 -> data_valid=1, data_out=0x11, one overrun pulse at second stop sample; assert data_ready -> data_valid clears.
REQ-032 Assert rst during data bit 4 of 0xFF, release, send 0x81 -> no output for aborted frame, data_out=0x81.
REQ-033 data_valid=1 with 0x10 held, assert data_ready exactly at stop sample of 0x20 -> data_valid stays 1, data_out=0x20, no overrun.
